mb_crc_serial_tx: RTL and testbench
===================================

# mb_crc_serial_tx

Serial-link transmitter. It accepts one parallel byte per handshake, then drives a framed bitstream onto the link: a start bit, the data MSB-first, and a 4-bit CRC MSB-first. It sits directly upstream of the JK-flip-flop-based receiver/CRC-checker chain, which samples `SDO` one bit per `CLK`. It is the only producer of the serial line in the design.

## Interface
Parameters:
- `DATA_W`, default 8: payload bits per frame.
- `CRC_W`, default 4: CRC bits per frame. Fixed to the package constant; do not override.
- `POLY`, default 4'b0011: CRC polynomial x^4+x+1, with the x^4 term implied.

Ports:
- `CLK` input 1: single clock. All state updates on the rising edge.
- `CLR` input 1: asynchronous, active-low reset.
- `LOAD_VALID` input 1: upstream has a byte on `LOAD_DATA`.
- `LOAD_DATA` input DATA_W: payload. Sampled only on the accept edge.
- `LOAD_READY` output 1: block can accept a byte this cycle.
- `SDO` output 1: serial data out. Registered.
- `SDO_VALID` output 1: `SDO` carries a frame bit this cycle.
- `FRAME_START` output 1: pulses with the start-bit cycle.
- `FRAME_END` output 1: pulses with the last CRC-bit cycle.
- `FRAME_CNT` output 8: count of completed frames. Wraps 255→0.

## Operation
- Accept rule: a byte is accepted on a rising edge where `LOAD_VALID && LOAD_READY`.
- `LOAD_READY` is 1 in IDLE, and also in the final CRC-bit cycle. The second case allows back-to-back frames with no idle gap.
- FSM states: IDLE, START, DATA, CRC.
  - IDLE→START on accept.
  - START→DATA after 1 cycle.
  - DATA→CRC after DATA_W cycles.
  - CRC→START after CRC_W cycles if an accept occurred in the last CRC cycle; otherwise CRC→IDLE.
- Output per state:
  - START: `SDO`=1, `SDO_VALID`=1, `FRAME_START`=1. The CRC register clears to 0.
  - DATA: `SDO`=shift[DATA_W-1]. The shift register moves left by one each cycle.
  - CRC update, once per data bit: fb = data_bit ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - CRC: `SDO`=crc[CRC_W-1]. The CRC register shifts left with 0 fill and takes no further CRC update.
  - Last CRC cycle: `FRAME_END`=1, and `FRAME_CNT` increments on that edge.
  - IDLE: `SDO`=0, `SDO_VALID`=0, `FRAME_START`=0, `FRAME_END`=0.
- Frame length is 1+DATA_W+CRC_W cycles, i.e. 13 at the defaults.
- `LOAD_VALID` asserted while `LOAD_READY`=0 is ignored. Upstream holds it; no byte is lost or duplicated.
- Reset: on `CLR`=0, asynchronously and immediately:
  - FSM→IDLE.
  - `SDO`=0, `SDO_VALID`=0, `FRAME_START`=0, `FRAME_END`=0, `FRAME_CNT`=0.
  - `LOAD_READY`=1 once `CLR` deasserts.
  - Shift and CRC registers→0.
  - A reset mid-frame aborts the frame. No partial CRC is emitted and `FRAME_CNT` does not count the frame.

## Timing
- Accept on edge N → start bit on `SDO` in cycle N+1 (registered).
- Data bit i (MSB i=DATA_W-1) is driven in cycle N+2+(DATA_W-1-i).
- CRC bits are driven in cycles N+2+DATA_W … N+1+DATA_W+CRC_W.
- Back-to-back: the next frame's start bit follows the prior frame's last CRC bit with zero gap, and `SDO_VALID` stays 1 throughout.
- Deassertion of `CLR` is synchronized to `CLK` externally. The block is not required to handle a reset release close to a clock edge.

## Structure
- Shared package `mb_serial_pkg`:
  - `CRC_W`=4.
  - `CRC_POLY`=4'b0011.
  - `FRAME_LEN` function of DATA_W.
  - Enum `tx_state_t` {IDLE, START, DATA, CRC}.
  - The receiver/checker imports the same package.
- One sub-module, `mb_crc4_lfsr`:
  - Ports: CLK, CLR, clear, enable, shift_out, din, crc.
  - Serial CRC update and CRC shift-out.
  - Reused by the receiver-side checker.
- Bit counter sized $clog2(DATA_W+1), shared by the DATA and CRC phases.

## Test plan
- Reset, then 0x00 accepted → 13-cycle frame on `SDO`: 1, 00000000, 0000. `FRAME_START` in cycle 1, `FRAME_END` in cycle 13, `FRAME_CNT`=1.
- 0x80 → `SDO`: 1, 10000000, CRC 1110 (0xE).
- 0x01 → CRC 0011 (0x3). Then 0x80 presented during the last CRC cycle → second frame starts the next cycle with no gap. `FRAME_CNT`=2.
- `LOAD_VALID` held high through a frame with the byte changing mid-frame → the transmitted payload equals the byte at the accept edge. Exactly one accept per frame.
- `CLR` pulsed low during data bit 4 → `SDO` and `SDO_VALID` go 0 immediately and `FRAME_CNT` is unchanged. The next accepted byte produces a correct full frame.
- 256 back-to-back frames → `FRAME_CNT` wraps to 0 and every CRC matches the reference model.

Source files
------------

// File: rtl/mb_crc_serial_tx_pkg.sv
// Shared definitions for the serial link transmitter and the receiver-side checker.
// Holds the CRC width and polynomial, the frame length helper and the TX FSM states.
// Both ends of the link import this package so the framing stays consistent.
package mb_serial_pkg;

  localparam int CRC_W = 4;

  // x^4 + x + 1, x^4 term implied
  localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    CRC   = 2'd3
  } tx_state_t;

  // Cycles per frame: start bit, payload, CRC
  function automatic int FRAME_LEN(input int data_w);
    return 1 + data_w + CRC_W;
  endfunction

endpackage

// File: rtl/mb_crc_serial_tx_if.sv
// Parallel load handshake into the serial transmitter.
// No latency of its own; pure signal bundle.
// Upstream holds LOAD_VALID/LOAD_DATA until LOAD_READY is seen on a rising edge.
interface mb_crc_serial_tx_if #(
  parameter int DATA_W = 8
);

  logic              LOAD_VALID;
  logic [DATA_W-1:0] LOAD_DATA;
  logic              LOAD_READY;

  modport master (
    output LOAD_VALID,
    output LOAD_DATA,
    input  LOAD_READY
  );

  modport slave (
    input  LOAD_VALID,
    input  LOAD_DATA,
    output LOAD_READY
  );

endinterface

// File: rtl/mb_crc_serial_tx_lfsr.sv
// Serial CRC generator: one bit per enable, then shifts the remainder out MSB-first.
// Register updates on the same edge as enable/shift_out; crc is a plain register output.
// No handshake; the owner sequences clear/enable/shift_out cycle by cycle.
module mb_crc4_lfsr #(
  parameter int                CRC_W = mb_serial_pkg::CRC_W,
  parameter logic [CRC_W-1:0]  POLY  = mb_serial_pkg::CRC_POLY
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             clear,
  input  logic             enable,
  input  logic             shift_out,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = din ^ crc[CRC_W-1];

  // Clear wins over update; shift-out fills with zeros and takes no feedback
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end else if (shift_out) begin
      crc <= {crc[CRC_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mb_crc_serial_tx.sv
// Serial link transmitter: start bit, payload MSB-first, then 4-bit CRC MSB-first.
// Start bit appears on SDO the cycle after the accept edge; frame is 1+DATA_W+CRC_W cycles.
// LOAD_READY only in IDLE or the last CRC cycle, so back-to-back frames have no gap.
module mb_crc_serial_tx
  import mb_serial_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                CRC_W  = mb_serial_pkg::CRC_W,
  parameter logic [CRC_W-1:0]  POLY   = mb_serial_pkg::CRC_POLY
) (
  input  logic                CLK,
  input  logic                CLR,
  mb_crc_serial_tx_if.slave   load,
  output logic                SDO,
  output logic                SDO_VALID,
  output logic                FRAME_START,
  output logic                FRAME_END,
  output logic [7:0]          FRAME_CNT
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt;
  logic [CRC_W-1:0]  crc;
  logic              accept;
  logic              last_data;
  logic              last_crc;

  assign last_data       = (state == DATA) && (cnt == '0);
  assign last_crc        = (state == CRC)  && (cnt == '0);
  assign load.LOAD_READY = (state == IDLE) || last_crc;
  assign accept          = load.LOAD_VALID && load.LOAD_READY;

  // CRC folds in each payload bit on the edge that moves it onto SDO,
  // so the remainder is complete by the edge that leaves the last data cycle.
  mb_crc4_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_crc (
    .CLK       (CLK),
    .CLR       (CLR),
    .clear     (accept),
    .enable    ((state == START) || ((state == DATA) && !last_data)),
    .shift_out (last_data || (state == CRC)),
    .din       (shift_q[DATA_W-1]),
    .crc       (crc)
  );

  // Frame sequencer with registered line outputs; cnt counts down through DATA then CRC
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state       <= IDLE;
      shift_q     <= '0;
      cnt         <= '0;
      SDO         <= 1'b0;
      SDO_VALID   <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
      FRAME_CNT   <= 8'd0;
    end else begin
      if (last_crc) begin
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      if (accept) begin
        state       <= START;
        shift_q     <= load.LOAD_DATA;
        SDO         <= 1'b1;
        SDO_VALID   <= 1'b1;
        FRAME_START <= 1'b1;
        FRAME_END   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            SDO         <= 1'b0;
            SDO_VALID   <= 1'b0;
            FRAME_START <= 1'b0;
            FRAME_END   <= 1'b0;
          end
          START: begin
            state       <= DATA;
            SDO         <= shift_q[DATA_W-1];
            shift_q     <= {shift_q[DATA_W-2:0], 1'b0};
            cnt         <= CNT_W'(DATA_W - 1);
            FRAME_START <= 1'b0;
          end
          DATA: begin
            if (cnt == '0) begin
              state     <= CRC;
              SDO       <= crc[CRC_W-1];
              cnt       <= CNT_W'(CRC_W - 1);
              FRAME_END <= (CRC_W == 1);
            end else begin
              SDO     <= shift_q[DATA_W-1];
              shift_q <= {shift_q[DATA_W-2:0], 1'b0};
              cnt     <= cnt - 1'b1;
            end
          end
          CRC: begin
            if (cnt == '0) begin
              state     <= IDLE;
              SDO       <= 1'b0;
              SDO_VALID <= 1'b0;
              FRAME_END <= 1'b0;
            end else begin
              SDO       <= crc[CRC_W-1];
              cnt       <= cnt - 1'b1;
              FRAME_END <= (cnt == CNT_W'(1));
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mb_crc_serial_tx.sv
// Self-checking bench for mb_crc_serial_tx: frame model built by polynomial division.
// Compares every cycle on the falling edge; inputs change 1 time unit after the rising edge.
// Upstream holds LOAD_VALID until it observes LOAD_READY.
module tb_mb_crc_serial_tx;
  import mb_serial_pkg::*;

  localparam int DW = 8;
  localparam int FL = FRAME_LEN(DW);

  logic       CLK = 1'b0;
  logic       CLR;
  logic       SDO, SDO_VALID, FRAME_START, FRAME_END;
  logic [7:0] FRAME_CNT;

  always #5 CLK = ~CLK;

  mb_crc_serial_tx_if #(.DATA_W(DW)) load ();

  mb_crc_serial_tx #(.DATA_W(DW)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .load        (load),
    .SDO         (SDO),
    .SDO_VALID   (SDO_VALID),
    .FRAME_START (FRAME_START),
    .FRAME_END   (FRAME_END),
    .FRAME_CNT   (FRAME_CNT)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [2:0]  expq[$];        // {sdo, frame_start, frame_end} per cycle
  logic [2:0]  e;
  logic [7:0]  exp_cnt = 8'd0;
  logic [7:0]  prev_cnt = 8'd0;
  logic [12:0] cap = '0;
  logic [12:0] last_frame = '1;
  int          starts_seen = 0;
  bit          saw_wrap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of d(x)*x^4 divided by x^4+x+1
  function automatic logic [3:0] crc_ref(input logic [7:0] d);
    logic [11:0] r;
    r = {d, 4'b0000};
    for (int i = 11; i >= 4; i--)
      if (r[i]) r = r ^ (12'h013 << (i - 4));
    return r[3:0];
  endfunction

  task automatic push_frame(input logic [7:0] d);
    logic [3:0] c;
    c = crc_ref(d);
    expq.push_back(3'b110);
    for (int i = DW - 1; i >= 0; i--) expq.push_back({d[i], 2'b00});
    for (int i = 3; i >= 0; i--) expq.push_back({c[i], 1'b0, (i == 0)});
  endtask

  // Per-cycle comparison against the frame model
  always @(negedge CLK) begin
    if (!CLR) begin
      expq.delete();
      exp_cnt = 8'd0;
      check("rst_sdo", SDO, 0);
      check("rst_sdo_valid", SDO_VALID, 0);
      check("rst_frame_start", FRAME_START, 0);
      check("rst_frame_end", FRAME_END, 0);
      check("rst_frame_cnt", FRAME_CNT, 0);
    end else begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("sdo", SDO, e[2]);
        check("sdo_valid", SDO_VALID, 1);
      end else begin
        e = 3'b000;
        check("idle_sdo", SDO, 0);
        check("idle_sdo_valid", SDO_VALID, 0);
      end
      check("frame_start", FRAME_START, e[1]);
      check("frame_end", FRAME_END, e[0]);
      check("frame_cnt", FRAME_CNT, exp_cnt);
      if (prev_cnt == 8'd255 && FRAME_CNT == 8'd0) saw_wrap = 1;
      prev_cnt = FRAME_CNT;
      if (SDO_VALID) cap = {cap[11:0], SDO};
      if (FRAME_END) last_frame = cap;
      if (FRAME_START) starts_seen++;
      if (e[0]) exp_cnt = exp_cnt + 8'd1;
      check("load_ready", load.LOAD_READY, expq.size() == 0);
      if (load.LOAD_VALID && expq.size() == 0) push_frame(load.LOAD_DATA);
    end
  end

  // Wait (bounded) for the accept of the currently offered byte; returns 1 time unit after it
  task automatic wait_accept(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      cycles++;
      if (load.LOAD_READY) begin
        @(posedge CLK);
        #1;
        return;
      end
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int cyc;
    load.LOAD_VALID = 1'b1;
    load.LOAD_DATA  = d;
    wait_accept(cyc);
    load.LOAD_VALID = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int cyc;
    int s0;
    CLR = 1'b0;
    load.LOAD_VALID = 1'b0;
    load.LOAD_DATA  = '0;
    repeat (3) @(posedge CLK);
    #3 CLR = 1'b1;
    idle_cycles(1);
    check("ready_after_reset", load.LOAD_READY, 1);

    // Model pinned by hand-computed CRCs
    check("model_crc_80", crc_ref(8'h80), 4'hE);
    check("model_crc_01", crc_ref(8'h01), 4'h3);
    check("model_crc_00", crc_ref(8'h00), 4'h0);

    // Abort during data bit 4 of 0x5A (bit 4 is 1)
    send_byte(8'h5A);
    repeat (4) @(posedge CLK);
    #3;
    check("abort_bit4_before", SDO, 1);
    CLR = 1'b0;
    #1;
    check("abort_sdo", SDO, 0);
    check("abort_sdo_valid", SDO_VALID, 0);
    check("abort_frame_cnt", FRAME_CNT, 0);
    @(posedge CLK);
    #3 CLR = 1'b1;
    idle_cycles(2);

    // Single frames
    send_byte(8'h00);
    idle_cycles(FL + 1);
    check("frame_00", last_frame, 13'b1_00000000_0000);
    check("cnt_after_00", FRAME_CNT, 1);

    send_byte(8'h80);
    idle_cycles(FL + 1);
    check("frame_80", last_frame, 13'b1_10000000_1110);
    check("cnt_after_80", FRAME_CNT, 2);

    // 0x01 then 0x80 offered into the last CRC cycle
    load.LOAD_VALID = 1'b1;
    load.LOAD_DATA  = 8'h01;
    wait_accept(cyc);
    load.LOAD_DATA  = 8'h80;
    wait_accept(cyc);
    load.LOAD_VALID = 1'b0;
    check("b2b_gap", cyc, FL);
    check("frame_01", last_frame, 13'b1_00000001_0011);
    idle_cycles(FL + 1);
    check("frame_80_b2b", last_frame, 13'b1_10000000_1110);
    check("cnt_after_b2b", FRAME_CNT, 4);

    // Valid held, byte changed mid-frame
    s0 = starts_seen;
    load.LOAD_VALID = 1'b1;
    load.LOAD_DATA  = 8'h3C;
    wait_accept(cyc);
    idle_cycles(3);
    load.LOAD_DATA  = 8'hC3;
    wait_accept(cyc);
    load.LOAD_VALID = 1'b0;
    idle_cycles(FL + 1);
    check("held_valid_starts", starts_seen - s0, 2);
    check("frame_c3", last_frame, {1'b1, 8'hC3, crc_ref(8'hC3)});
    check("cnt_after_held", FRAME_CNT, 6);

    // 256 back-to-back frames, counter wraps back to its start value
    s0 = starts_seen;
    load.LOAD_VALID = 1'b1;
    load.LOAD_DATA  = 8'($urandom);
    for (int k = 0; k < 256; k++) begin
      wait_accept(cyc);
      if (k > 0) check("b2b_gap_loop", cyc, FL);
      load.LOAD_DATA = 8'($urandom);
    end
    load.LOAD_VALID = 1'b0;
    idle_cycles(FL + 2);
    check("wrap_starts", starts_seen - s0, 256);
    check("wrap_seen", saw_wrap, 1);
    check("cnt_after_wrap", FRAME_CNT, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
